disp_cmd_fifo_writer: RTL
=========================

// Module: disp_cmd_fifo_writer
// PURPOSE
//  Producer end of the display-command FIFO. The vga core is the consumer and
//  reads that FIFO through disp_cmd_rd / nef.
//  Accepts 1-3 byte command packets (opcode + 0..2 args) over a valid/ready
//  port and serialises them into the external byte FIFO.
//  Drives an active-low write strobe with programmable setup/pulse/hold.
//  Never writes while the FIFO reports full.
//  Sits on the host/bridge FPGA between the command source and the FIFO.
// PARAMETERS
//  SETUP_CYCLES  1  data-valid cycles before strobe falls (>=1)
//  PULSE_CYCLES  2  cycles fifo_nwr held low (>=1)
//  HOLD_CYCLES   1  data-valid cycles after strobe rises (>=1)
//  SYNC_STAGES   2  flops synchronising fifo_nff_in (>=2)
// PORTS
//  clk           in   1   system clock
//  nrst          in   1   reset, synchronous, active-high
//  cmd_valid     in   1   packet offered
//  cmd_ready     out  1   packet accepted when cmd_valid & cmd_ready
//  cmd_opcode    in   8   first byte written
//  cmd_arg0      in   8   second byte (written if cmd_len>=1)
//  cmd_arg1      in   8   third byte (written if cmd_len==2)
//  cmd_len       in   2   number of arg bytes, 0..2; 3 treated as 2
//  fifo_nff_in   in   1   FIFO full flag, active-low, asynchronous
//  fifo_data     out  8   byte to FIFO
//  fifo_nwr      out  1   FIFO write strobe, active-low
//  busy          out  1   packet in progress (state != IDLE)
//  bytes_sent    out  16  count of completed byte writes, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (nrst=1 at posedge): state=IDLE, cmd_ready=0 for that cycle,
//   fifo_nwr=1, fifo_data=0x00, busy=0, bytes_sent=0, gap=0.
//   Sync chain preset to 0 (full).
//  Reset mid-operation aborts immediately. A pulse in progress is terminated
//   by fifo_nwr=1 on the next edge, and the partial packet is discarded.
//  nff_s = last stage of fifo_nff_in synchroniser; only nff_s is ever used.
//  All outputs registered; cmd_ready = (state==IDLE) & ~nrst.
//  FSM:
//   IDLE: on accept, latch opcode/arg0/arg1 and nbytes=min(cmd_len,2)+1;
//    set idx=0 and go WAIT_NF.
//   WAIT_NF: stay while nff_s==0 or gap!=0.
//    Otherwise load fifo_data=byte[idx] and go SETUP with cnt=SETUP_CYCLES-1.
//   SETUP: fifo_nwr=1. At cnt==0 go PULSE (fifo_nwr<=0, cnt=PULSE_CYCLES-1).
//   PULSE: fifo_nwr=0. At cnt==0 set fifo_nwr<=1, bytes_sent+=1,
//    gap<=SYNC_STAGES+1, go HOLD with cnt=HOLD_CYCLES-1.
//   HOLD: fifo_data unchanged. At cnt==0: if idx==nbytes-1 go IDLE,
//    else idx+=1 and go WAIT_NF.
//  gap decrements every cycle while nonzero, in any state. It covers
//   synchroniser latency so a stale "not full" is never trusted after a write.
//  fifo_data is stable from entry to SETUP through the last HOLD cycle.
//   It changes only on the WAIT_NF->SETUP transition.
//  Full asserted during SETUP/PULSE/HOLD is ignored; the current byte always
//   completes. Full is checked only in WAIT_NF.
//  Min byte period (defaults, FIFO never full):
//   1 WAIT_NF + 1 SETUP + 2 PULSE + 1 HOLD = 5 cycles.
//   The next WAIT_NF then stalls until gap expires.
//  Back-to-back packets: IDLE lasts >=1 cycle between packets. cmd_ready rises
//   the cycle after the last HOLD.
//  cmd_* inputs are ignored except at accept.
// TESTING
//  1 Reset: hold nrst=1 for 3 cycles -> fifo_nwr=1, fifo_data=0, busy=0,
//    bytes_sent=0, cmd_ready=0; cmd_ready=1 on the first cycle after release.
//  2 Single byte: nff=1, offer opcode 0x41 len=0 -> exactly one low pulse of
//    2 cycles; fifo_data=0x41 from 1 cycle before the fall to 1 cycle after
//    the rise; bytes_sent=1; back to IDLE.
//  3 Three bytes: opcode 0x10, args 0xAB,0xCD, len=2 -> pulses in order
//    0x10,0xAB,0xCD; rising edges >= 1+SYNC_STAGES+1+SETUP+PULSE cycles apart;
//    bytes_sent=3.
//  4 Full stall: hold nff=0 before accept, then release after 20 cycles ->
//    no pulse while nff_s==0; the first fall occurs SYNC_STAGES+SETUP+1 cycles
//    after release.
//  5 Full mid-pulse: drop nff during PULSE of byte 0 of a len=1 packet ->
//    byte 0 completes normally; byte 1 waits until nff returns high.
//  6 Reset mid-pulse, plus wrap: assert nrst while fifo_nwr=0 -> fifo_nwr=1
//    next edge, busy=0; separately preload bytes_sent=0xFFFF and send 1 byte
//    -> bytes_sent=0x0000.

Source files
------------

// File: rtl/disp_cmd_fifo_writer_if.sv
// Command packet port between a command source and disp_cmd_fifo_writer.
// A packet (opcode plus 0..2 argument bytes) moves on a cycle where
// cmd_valid and cmd_ready are both high.
//   cmd_valid   source -> writer  packet offered
//   cmd_ready   writer -> source  writer idle and able to accept
//   cmd_opcode  source -> writer  first byte
//   cmd_arg0    source -> writer  second byte (cmd_len >= 1)
//   cmd_arg1    source -> writer  third byte (cmd_len >= 2)
//   cmd_len     source -> writer  number of argument bytes, 3 behaves as 2
interface disp_cmd_fifo_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_opcode;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic [1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_arg0,
        output cmd_arg1,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_arg0,
        input  cmd_arg1,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/disp_cmd_fifo_writer.sv
// Producer end of the display-command byte FIFO read by the vga core.
// Takes 1-3 byte command packets and writes them one byte at a time into the
// external FIFO with an active-low write strobe of programmable
// setup/pulse/hold length. A byte is only started while the FIFO reports
// not-full; once started it always completes.
// Ports:
//   clk          system clock
//   nrst         synchronous reset, active high
//   cmd          command packet port (slave side)
//   fifo_nff_in  FIFO full flag, active low, asynchronous to clk
//   fifo_data    byte presented to the FIFO
//   fifo_nwr     FIFO write strobe, active low
//   busy         a packet is in progress
//   bytes_sent   completed byte writes, wrapping 16-bit count
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a packet, cmd_ready high
// WAIT_NF | next byte pending; waits for not-full and gap expiry
// SETUP   | data driven, strobe still high
// PULSE   | strobe low
// HOLD    | strobe back high, data still driven
module disp_cmd_fifo_writer #(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    disp_cmd_fifo_writer_if.slave       cmd,
    input  logic                        fifo_nff_in,
    output logic [7:0]                  fifo_data,
    output logic                        fifo_nwr,
    output logic                        busy,
    output logic [15:0]                 bytes_sent
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_NF = 3'd1;
    localparam logic [2:0] SETUP   = 3'd2;
    localparam logic [2:0] PULSE   = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;

    localparam int CNT_MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_SP > HOLD_CYCLES) ? CNT_MAX_SP : HOLD_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_W      = $clog2(SYNC_STAGES + 2);

    logic [2:0]             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [1:0]             idx, idx_nxt;
    logic [1:0]             last_idx;
    logic [7:0]             opcode_q, arg0_q, arg1_q;
    logic [7:0]             data_nxt;
    logic                   nwr_nxt;
    logic                   byte_done;
    logic                   accept;
    logic [SYNC_STAGES-1:0] sync;
    logic                   nff_s;
    logic [GAP_W-1:0]       gap;
    logic [15:0]            sent_cnt;

    assign nff_s      = sync[SYNC_STAGES-1];
    assign accept     = (state == IDLE) && cmd.cmd_valid && cmd.cmd_ready;
    assign bytes_sent = sent_cnt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        data_nxt  = fifo_data;
        nwr_nxt   = fifo_nwr;
        byte_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT_NF;
                    idx_nxt   = 2'd0;
                end
            end
            WAIT_NF: begin
                // gap keeps us from trusting a not-full that was sampled
                // before the previous write could be reflected by the FIFO.
                if (nff_s && (gap == '0)) begin
                    case (idx)
                        2'd0:    data_nxt = opcode_q;
                        2'd1:    data_nxt = arg0_q;
                        default: data_nxt = arg1_q;
                    endcase
                    state_nxt = SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                nwr_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    nwr_nxt   = 1'b0;
                    cnt_nxt   = CNT_W'(PULSE_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PULSE: begin
                nwr_nxt = 1'b0;
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    nwr_nxt   = 1'b1;
                    byte_done = 1'b1;
                    cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (idx == last_idx) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = WAIT_NF;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= 2'd0;
            last_idx      <= 2'd0;
            opcode_q      <= 8'h00;
            arg0_q        <= 8'h00;
            arg1_q        <= 8'h00;
            fifo_data     <= 8'h00;
            fifo_nwr      <= 1'b1;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            sync          <= '0;
            gap           <= '0;
            sent_cnt      <= 16'h0000;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            fifo_data     <= data_nxt;
            fifo_nwr      <= nwr_nxt;
            busy          <= (state_nxt != IDLE);
            cmd.cmd_ready <= (state_nxt == IDLE);
            sync          <= {sync[SYNC_STAGES-2:0], fifo_nff_in};
            sent_cnt      <= sent_cnt + {15'd0, byte_done};
            if (accept) begin
                opcode_q <= cmd.cmd_opcode;
                arg0_q   <= cmd.cmd_arg0;
                arg1_q   <= cmd.cmd_arg1;
                last_idx <= (cmd.cmd_len == 2'd3) ? 2'd2 : cmd.cmd_len;
            end
            if (byte_done) begin
                gap <= GAP_W'(SYNC_STAGES + 1);
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end

endmodule
